vga_time_overlay: RTL and testbench
===================================

Name: vga_time_overlay

Overview:
- Parametrised, registered successor to the clock/alarm text renderer.
- Draws N_ROWS rows of six-digit HH:MM:SS time over a solid background.
- Blinks the digit currently being edited and flashes the background while the alarm rings.
- Sits between the VGA sync generator and the RGB output pins, and drives the 12-bit RGB bus with a fixed 1-clock latency.

Parameters:
- N_ROWS, 2, number of time rows (row 0 = current time, row 1 = alarm, more allowed).
- X0, 270, left x of hour-MSB digit.
- Y0, 232, top y of row 0.
- ROW_PITCH, 30, vertical spacing between rows in pixels.
- DIGIT_PITCH, 20, horizontal spacing between digit cells; colon occupies the gap after digits 1 and 3.
- BLINK_FRAMES, 30, frames per blink half-period (30 frames = 0.5 s at 60 Hz).
- FG_COLOR, 12'h000, normal digit/colon colour.
- EDIT_COLOR, 12'hF00, colour of all rows while edit_mode=1.
- BG_COLOR, 12'hFFF, background.
- ALARM_BG, 12'hF80, alternate background while alarm_ring=1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- video_on  in  1  from sync generator
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- row_digits  in  24*N_ROWS  BCD digits; row r occupies bits [24r+23:24r], ordered hourMSB..secLSB, MSB first
- edit_mode  in  1  set-time mode active
- edit_row  in  clog2(N_ROWS) (min 1)  row being edited
- edit_digit  in  3  digit 0..5 being edited (0 = hourMSB)
- alarm_ring  in  1  alarm currently sounding
- frame_tick  out  1  one-clock pulse at start of each frame
- rgb  out  12  registered pixel colour

Behaviour:
- Reset (asynchronous, active-high):
  - rgb=0 and frame_tick=0.
  - Frame counter=0; blink_phase=0 (visible); stored previous-origin flag=1.
- Frame tick:
  - at_origin = (pix_x==0 && pix_y==0), registered each clock.
  - frame_tick=1 for exactly one clock when at_origin=1 and the previous registered value was 0.
  - Pixel coordinates held for several clocks (pixel-enable < clk) therefore still give one pulse per frame.
- Blink counter:
  - On each frame_tick, counter increments.
  - At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - A rising edge of edit_mode or alarm_ring clears counter and blink_phase in the same clock, so the first half-period is always full and visible.
- Geometry per row r: cell top = Y0 + r*ROW_PITCH. Digit d left x is:
  - X0 + d*DIGIT_PITCH for d=0,1
  - X0 + 40 + (d-2)*DIGIT_PITCH for d=2,3
  - X0 + 80 + (d-4)*DIGIT_PITCH for d=4,5
  - (matches 270/290/310/330/350/370 at defaults; digit glyph 16x16 via digit_display).
- Colons:
  - 2x2 squares at x offsets 37..38 and 77..78 from X0.
  - y offsets 5..6 and 11..12 from the row top.
- BCD >9 renders as blank (glyph forced off), and no other effect.
- Edit blink: when edit_mode=1, edit_row<N_ROWS and blink_phase=1, the glyph of digit edit_digit in row edit_row is suppressed. An out-of-range edit_row or edit_digit>5 suppresses nothing.
- Colour priority (combinational, then registered):
  - !video_on → 0
  - else glyph/colon on → (edit_mode ? EDIT_COLOR : FG_COLOR)
  - else alarm_ring && blink_phase → ALARM_BG
  - else BG_COLOR
- Latency: rgb reflects pix_x/pix_y/video_on/all inputs sampled at the previous clock edge (1 clk).
- Reset mid-frame: output goes to 0 immediately; normal rendering resumes on the next clock. The blink restarts visible.

Decomposition:
- Shared package/header: colour localparams (BLACK, WHITE, RED, ORANGE), GLYPH_W=16, GLYPH_H=16, DIGITS_PER_ROW=6.
- Reuse existing digit_display for glyph lookup, instantiated via generate over N_ROWS*6.
- One new sub-module, blink_timer (frame-tick edge detect + counter + phase, restart input), so the alarm and edit logic share one timer.

Test Plan:
- Reset asserted mid-line with pix=(300,240) → rgb=0 same cycle. After release with video_on=1, pix=(0,0) → rgb=12'hFFF one clock later.
- row_digits row0 = 1,2,3,4,5,6; sweep a pixel inside the hourMSB glyph stroke at (271..285,232..247) → rgb=FG_COLOR. Pixel (307,237) → colon FG. Pixel (260,240) → BG.
- Hold pix=(0,0) for 4 clocks, 3 times across frames → exactly one frame_tick per frame. With BLINK_FRAMES=2, blink_phase toggles every 2 ticks.
- edit_mode=1, edit_row=1, edit_digit=3 → every pixel of row 1 digit 3 (x=330..345, y=262..277) is BG when blink_phase=1 and EDIT_COLOR when 0. Other digits are always EDIT_COLOR.
- alarm_ring 0→1 → counter clears, first BLINK_FRAMES frames have BG 12'hFFF, next BLINK_FRAMES have 12'hF80. Digits stay FG throughout.
- Digit value 4'hC in row0 secLSB → that cell fully BG. Other rows unaffected. video_on=0 → rgb=0 regardless of all inputs.

Source files
------------

// File: rtl/vga_time_overlay_pkg.sv
// ============================================================================
// Module   : vga_time_overlay_pkg
// Purpose  : Shared colours, glyph geometry and helpers for the time overlay.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_time_overlay_pkg;

    typedef logic [11:0] rgb_t;

    localparam rgb_t BLACK  = 12'h000;
    localparam rgb_t WHITE  = 12'hFFF;
    localparam rgb_t RED    = 12'hF00;
    localparam rgb_t ORANGE = 12'hF80;

    localparam int GLYPH_W        = 16;
    localparam int GLYPH_H        = 16;
    localparam int DIGITS_PER_ROW = 6;

    // Digits are laid out in pairs; each pair is shifted by 40 px to leave room for a colon.
    function automatic int digit_x_offset(input int d, input int pitch);
        if (d < 2)      return d * pitch;
        else if (d < 4) return 40 + (d - 2) * pitch;
        else            return 80 + (d - 4) * pitch;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_display.sv
// ============================================================================
// Module   : digit_display
// Purpose  : 16x16 seven-segment style glyph lookup for one BCD digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_display (
    input  logic [3:0] digit,
    input  logic [3:0] col,
    input  logic [3:0] row,
    output logic       pixel_on
);

    logic [6:0] w_seg;  // {a,b,c,d,e,f,g}
    logic w_mid_col, w_left, w_right, w_top, w_bot, w_upper, w_lower, w_mid_row;

    always_comb begin
        w_seg = 7'b0000000;
        case (digit)
            4'd0: w_seg = 7'b1111110;
            4'd1: w_seg = 7'b0110000;
            4'd2: w_seg = 7'b1101101;
            4'd3: w_seg = 7'b1111001;
            4'd4: w_seg = 7'b0110011;
            4'd5: w_seg = 7'b1011011;
            4'd6: w_seg = 7'b1011111;
            4'd7: w_seg = 7'b1110000;
            4'd8: w_seg = 7'b1111111;
            4'd9: w_seg = 7'b1111011;
            default: w_seg = 7'b0000000;
        endcase
    end

    assign w_mid_col = (col >= 4'd2) && (col <= 4'd13);
    assign w_left    = (col <= 4'd1);
    assign w_right   = (col >= 4'd14);
    assign w_top     = (row <= 4'd1);
    assign w_bot     = (row >= 4'd14);
    assign w_upper   = (row >= 4'd1) && (row <= 4'd7);
    assign w_lower   = (row >= 4'd8) && (row <= 4'd14);
    assign w_mid_row = (row == 4'd7) || (row == 4'd8);

    assign pixel_on = (w_seg[6] & w_top   & w_mid_col)
                    | (w_seg[5] & w_right & w_upper)
                    | (w_seg[4] & w_right & w_lower)
                    | (w_seg[3] & w_bot   & w_mid_col)
                    | (w_seg[2] & w_left  & w_lower)
                    | (w_seg[1] & w_left  & w_upper)
                    | (w_seg[0] & w_mid_row & w_mid_col);

endmodule

`default_nettype wire

// File: rtl/vga_time_overlay_blink_timer.sv
// ============================================================================
// Module   : blink_timer
// Purpose  : Frame-start detector plus frame counter driving a blink phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       restart,
    output logic       frame_tick,
    output logic       blink_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             origin_q, origin_d;
    logic             tick_q, tick_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        origin_d = (pix_x == 10'd0) && (pix_y == 10'd0);
        // Origin may be held for several clocks when the pixel enable is slower than clk.
        tick_d   = origin_d && !origin_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick_d) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = !phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            origin_q <= 1'b1;
            tick_q   <= 1'b0;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            origin_q <= origin_d;
            tick_q   <= tick_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
        end
    end

    assign frame_tick  = tick_q;
    // Masked during a restart so the clock that restarts the blink already renders visible.
    assign blink_phase = phase_q && !restart;

endmodule

`default_nettype wire

// File: rtl/vga_time_overlay.sv
// ============================================================================
// Module   : vga_time_overlay
// Purpose  : Renders N_ROWS of HH:MM:SS over a background, registered RGB out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_time_overlay
    import vga_time_overlay_pkg::*;
#(
    parameter int   N_ROWS       = 2,
    parameter int   X0           = 270,
    parameter int   Y0           = 232,
    parameter int   ROW_PITCH    = 30,
    parameter int   DIGIT_PITCH  = 20,
    parameter int   BLINK_FRAMES = 30,
    parameter rgb_t FG_COLOR     = BLACK,
    parameter rgb_t EDIT_COLOR   = RED,
    parameter rgb_t BG_COLOR     = WHITE,
    parameter rgb_t ALARM_BG     = ORANGE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           video_on,
    input  logic [9:0]                     pix_x,
    input  logic [9:0]                     pix_y,
    input  logic [24*N_ROWS-1:0]           row_digits,
    input  logic                           edit_mode,
    input  logic [sel_width(N_ROWS)-1:0]   edit_row,
    input  logic [2:0]                     edit_digit,
    input  logic                           alarm_ring,
    output logic                           frame_tick,
    output logic [11:0]                    rgb
);

    localparam int ER_W = sel_width(N_ROWS);
    localparam int N_CELLS = N_ROWS * DIGITS_PER_ROW;

    localparam logic [11:0] COLON1_L = 12'(X0 + 37);
    localparam logic [11:0] COLON1_R = 12'(X0 + 38);
    localparam logic [11:0] COLON2_L = 12'(X0 + 77);
    localparam logic [11:0] COLON2_R = 12'(X0 + 78);

    logic               edit_q, edit_d;
    logic               alarm_q, alarm_d;
    rgb_t               rgb_q, rgb_d;
    logic               w_restart;
    logic               w_blink_phase;
    logic [11:0]        w_px, w_py;
    logic               w_colon_x;
    logic [N_CELLS-1:0] w_glyph_hit;
    logic [N_ROWS-1:0]  w_colon_hit;

    assign w_px      = {2'b00, pix_x};
    assign w_py      = {2'b00, pix_y};
    assign w_colon_x = ((w_px >= COLON1_L) && (w_px <= COLON1_R))
                    || ((w_px >= COLON2_L) && (w_px <= COLON2_R));

    assign w_restart = (edit_mode && !edit_q) || (alarm_ring && !alarm_q);

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk         (clk),
        .reset       (reset),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .restart     (w_restart),
        .frame_tick  (frame_tick),
        .blink_phase (w_blink_phase)
    );

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        localparam logic [11:0] TOP = 12'(Y0 + r * ROW_PITCH);

        assign w_colon_hit[r] = w_colon_x
            && (((w_py >= TOP + 12'd5)  && (w_py <= TOP + 12'd6))
             || ((w_py >= TOP + 12'd11) && (w_py <= TOP + 12'd12)));

        for (genvar d = 0; d < DIGITS_PER_ROW; d++) begin : g_digit
            localparam logic [11:0] LEFT = 12'(X0 + digit_x_offset(d, DIGIT_PITCH));

            logic [11:0] w_dx, w_dy;
            logic        w_in_cell, w_pixel_on, w_suppress;

            assign w_dx = w_px - LEFT;
            assign w_dy = w_py - TOP;
            assign w_in_cell = (w_px >= LEFT) && (w_dx < 12'(GLYPH_W))
                            && (w_py >= TOP)  && (w_dy < 12'(GLYPH_H));

            digit_display u_digit (
                .digit    (row_digits[24*r + 23 - 4*d -: 4]),
                .col      (w_dx[3:0]),
                .row      (w_dy[3:0]),
                .pixel_on (w_pixel_on)
            );

            assign w_suppress = edit_mode && w_blink_phase
                             && (edit_row == ER_W'(r)) && (edit_digit == 3'(d));

            assign w_glyph_hit[r*DIGITS_PER_ROW + d] = w_in_cell && w_pixel_on && !w_suppress;
        end
    end

    always_comb begin
        edit_d  = edit_mode;
        alarm_d = alarm_ring;
        rgb_d   = BG_COLOR;
        if (!video_on) begin
            rgb_d = BLACK;
        end else if ((|w_glyph_hit) || (|w_colon_hit)) begin
            rgb_d = edit_mode ? EDIT_COLOR : FG_COLOR;
        end else if (alarm_ring && w_blink_phase) begin
            rgb_d = ALARM_BG;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edit_q  <= 1'b0;
            alarm_q <= 1'b0;
            rgb_q   <= BLACK;
        end else begin
            edit_q  <= edit_d;
            alarm_q <= alarm_d;
            rgb_q   <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_time_overlay.sv
// ============================================================================
// Module   : tb_vga_time_overlay
// Purpose  : Directed self-checking bench for vga_time_overlay.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_time_overlay;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b1;
    logic [9:0]  pix_x = 10'd300;
    logic [9:0]  pix_y = 10'd240;
    logic [47:0] row_digits = {24'h128800, 24'h123456};
    logic        edit_mode = 1'b0;
    logic [0:0]  edit_row = 1'b0;
    logic [2:0]  edit_digit = 3'd0;
    logic        alarm_ring = 1'b0;
    logic        frame_tick;
    logic [11:0] rgb;

    int n_pass  = 0;
    int n_total = 0;

    vga_time_overlay #(
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .row_digits (row_digits),
        .edit_mode  (edit_mode),
        .edit_row   (edit_row),
        .edit_digit (edit_digit),
        .alarm_ring (alarm_ring),
        .frame_tick (frame_tick),
        .rgb        (rgb)
    );

    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic render(input int x, input int y);
        pix_x = 10'(x);
        pix_y = 10'(y);
        tick_clk();
    endtask

    task automatic do_frame();
        pix_x = 10'd0;
        pix_y = 10'd0;
        repeat (4) tick_clk();
        render(260, 240);
    endtask

    task automatic test_reset();
        repeat (2) tick_clk();
        #2 reset = 1'b0;
        render(260, 240);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL pre_reset_bg: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
        pix_x = 10'd300;
        pix_y = 10'd240;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (rgb !== 12'h000) $display("FAIL reset_async_rgb: got %h expected %h", rgb, 12'h000);
        else n_pass++;
        n_total++;
        if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", frame_tick);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        render(0, 0);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL post_reset_origin: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
        n_total++;
        if (frame_tick !== 1'b0) $display("FAIL no_tick_after_reset: got %b expected 0", frame_tick);
        else n_pass++;
        render(260, 240);
    endtask

    task automatic test_glyph();
        for (int y = 233; y <= 246; y++) begin
            render(285, y);
            n_total++;
            if (rgb !== 12'h000) $display("FAIL digit1_stroke y=%0d: got %h expected %h", y, rgb, 12'h000);
            else n_pass++;
        end
        render(277, 240);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL digit1_gap: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
        render(300, 240);
        n_total++;
        if (rgb !== 12'h000) $display("FAIL digit2_mid: got %h expected %h", rgb, 12'h000);
        else n_pass++;
        render(307, 237);
        n_total++;
        if (rgb !== 12'h000) $display("FAIL colon1_top: got %h expected %h", rgb, 12'h000);
        else n_pass++;
        render(308, 244);
        n_total++;
        if (rgb !== 12'h000) $display("FAIL colon1_bot: got %h expected %h", rgb, 12'h000);
        else n_pass++;
        render(309, 237);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL colon1_edge: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
        render(347, 243);
        n_total++;
        if (rgb !== 12'h000) $display("FAIL colon2: got %h expected %h", rgb, 12'h000);
        else n_pass++;
        render(260, 240);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL left_bg: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
    endtask

    task automatic test_frame_tick();
        for (int f = 0; f < 3; f++) begin
            int ticks;
            ticks = 0;
            pix_x = 10'd0;
            pix_y = 10'd0;
            repeat (4) begin
                tick_clk();
                if (frame_tick === 1'b1) ticks++;
            end
            pix_x = 10'd260;
            pix_y = 10'd240;
            repeat (3) begin
                tick_clk();
                if (frame_tick === 1'b1) ticks++;
            end
            n_total++;
            if (ticks != 1) $display("FAIL frame_tick_count frame=%0d: got %0d expected 1", f, ticks);
            else n_pass++;
        end
    endtask

    task automatic test_alarm();
        logic [11:0] exp_bg [4] = '{12'hFFF, 12'hF80, 12'hF80, 12'hFFF};
        alarm_ring = 1'b1;
        render(260, 240);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL alarm_restart_visible: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
        for (int f = 0; f < 4; f++) begin
            do_frame();
            render(260, 240);
            n_total++;
            if (rgb !== exp_bg[f]) $display("FAIL alarm_bg frame=%0d: got %h expected %h", f, rgb, exp_bg[f]);
            else n_pass++;
            render(285, 240);
            n_total++;
            if (rgb !== 12'h000) $display("FAIL alarm_digit_fg frame=%0d: got %h expected %h", f, rgb, 12'h000);
            else n_pass++;
        end
    endtask

    task automatic test_edit();
        int xs [4] = '{337, 345, 337, 330};
        int ys [4] = '{262, 270, 269, 263};
        alarm_ring = 1'b0;
        do_frame();
        do_frame();
        edit_mode  = 1'b1;
        edit_row   = 1'b1;
        edit_digit = 3'd3;
        render(337, 262);
        n_total++;
        if (rgb !== 12'hF00) $display("FAIL edit_restart_visible: got %h expected %h", rgb, 12'hF00);
        else n_pass++;
        render(285, 240);
        n_total++;
        if (rgb !== 12'hF00) $display("FAIL edit_row0_color: got %h expected %h", rgb, 12'hF00);
        else n_pass++;
        do_frame();
        do_frame();
        for (int i = 0; i < 4; i++) begin
            render(xs[i], ys[i]);
            n_total++;
            if (rgb !== 12'hFFF) $display("FAIL edit_blank (%0d,%0d): got %h expected %h", xs[i], ys[i], rgb, 12'hFFF);
            else n_pass++;
        end
        render(317, 262);
        n_total++;
        if (rgb !== 12'hF00) $display("FAIL edit_other_digit: got %h expected %h", rgb, 12'hF00);
        else n_pass++;
        render(345, 240);
        n_total++;
        if (rgb !== 12'hF00) $display("FAIL edit_other_row: got %h expected %h", rgb, 12'hF00);
        else n_pass++;
        edit_digit = 3'd6;
        render(337, 262);
        n_total++;
        if (rgb !== 12'hF00) $display("FAIL edit_digit_out_of_range: got %h expected %h", rgb, 12'hF00);
        else n_pass++;
        edit_row   = 1'b0;
        edit_digit = 3'd3;
        render(345, 240);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL edit_row0_blank: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
        render(345, 270);
        n_total++;
        if (rgb !== 12'hF00) $display("FAIL edit_row1_shown: got %h expected %h", rgb, 12'hF00);
        else n_pass++;
    endtask

    task automatic test_bad_bcd();
        edit_mode = 1'b0;
        render(377, 239);
        n_total++;
        if (rgb !== 12'h000) $display("FAIL sec_lsb_six: got %h expected %h", rgb, 12'h000);
        else n_pass++;
        row_digits[23:0] = 24'h12345C;
        render(377, 239);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL bcd_c_mid: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
        render(384, 240);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL bcd_c_right: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
        render(371, 233);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL bcd_c_left: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
        render(377, 262);
        n_total++;
        if (rgb !== 12'h000) $display("FAIL bcd_row1_intact: got %h expected %h", rgb, 12'h000);
        else n_pass++;
        render(357, 239);
        n_total++;
        if (rgb !== 12'h000) $display("FAIL bcd_neighbour_intact: got %h expected %h", rgb, 12'h000);
        else n_pass++;
    endtask

    task automatic test_video_off();
        video_on   = 1'b0;
        alarm_ring = 1'b1;
        edit_mode  = 1'b1;
        render(285, 240);
        n_total++;
        if (rgb !== 12'h000) $display("FAIL video_off_glyph: got %h expected %h", rgb, 12'h000);
        else n_pass++;
        render(260, 240);
        n_total++;
        if (rgb !== 12'h000) $display("FAIL video_off_bg: got %h expected %h", rgb, 12'h000);
        else n_pass++;
        video_on = 1'b1;
        render(260, 240);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL video_on_bg: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
        render(285, 240);
        n_total++;
        if (rgb !== 12'hF00) $display("FAIL video_on_edit_glyph: got %h expected %h", rgb, 12'hF00);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_frame();
        do_frame();
        render(260, 240);
        n_total++;
        if (rgb !== 12'hF80) $display("FAIL pre_reset_alarm_bg: got %h expected %h", rgb, 12'hF80);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (rgb !== 12'h000) $display("FAIL mid_frame_reset: got %h expected %h", rgb, 12'h000);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        render(260, 240);
        n_total++;
        if (rgb !== 12'hFFF) $display("FAIL reset_blink_visible: got %h expected %h", rgb, 12'hFFF);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_glyph();
        test_frame_tick();
        test_alarm();
        test_edit();
        test_bad_bcd();
        test_video_off();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
